// File: rtl/strength_pkg.sv
// Shared constants, colours and state encoding for the strength-meter drawing path.
// Also carries the on-screen test used when STRENGTH_DRAW_CLIP_EN is defined.
package strength_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    localparam logic [2:0] COL_BLACK   = 3'b000;
    localparam logic [2:0] COL_RED     = 3'b100;
    localparam logic [2:0] COL_MAGENTA = 3'b101;
    localparam logic [2:0] COL_YELLOW  = 3'b110;
    localparam logic [2:0] COL_WHITE   = 3'b111;

    localparam int METER_X0   = 45;
    localparam int METER_Y0   = 73;
    localparam int METER_STEP = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        DONE = 2'd2
    } draw_state_t;

    // The inputs are the unwrapped coordinates, one bit wider than the VGA bus.
    function automatic logic on_screen(input logic [8:0] ux, input logic [7:0] uy);
        return (ux < 9'(SCREEN_W)) && (uy < 8'(SCREEN_H));
    endfunction

endpackage

// File: rtl/strength_bar_drawer_pixel_scan_counter.sv
// Row-major cx/cy scan counter for one block, with a last-pixel flag.
// The next-value outputs let the owner register pixel coordinates in step with the counter.
module pixel_scan_counter #(
    parameter int BLOCK_W = 7,
    parameter int BLOCK_H = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       advance,
    output logic [2:0] cx,
    output logic [2:0] cy,
    output logic [2:0] cx_nxt,
    output logic [2:0] cy_nxt,
    output logic       last
);

    localparam logic [2:0] CX_MAX = 3'(BLOCK_W - 1);
    localparam logic [2:0] CY_MAX = 3'(BLOCK_H - 1);

    assign last = (cx == CX_MAX) && (cy == CY_MAX);

    always_comb begin
        cx_nxt = cx;
        cy_nxt = cy;
        if (clear) begin
            cx_nxt = 3'd0;
            cy_nxt = 3'd0;
        end else if (advance) begin
            if (cx == CX_MAX) begin
                cx_nxt = 3'd0;
                cy_nxt = (cy == CY_MAX) ? 3'd0 : cy + 3'd1;
            end else begin
                cx_nxt = cx + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cx <= 3'd0;
            cy <= 3'd0;
        end else begin
            cx <= cx_nxt;
            cy <= cy_nxt;
        end
    end

endmodule

// File: rtl/strength_bar_drawer.sv
// Rasterises one BLOCK_W x BLOCK_H block per request into the VGA write port.
// Define STRENGTH_DRAW_CLIP_EN to suppress plots of pixels falling off the 160x120 screen.
module strength_bar_drawer
    import strength_pkg::*;
#(
    parameter int BLOCK_W = 7,
    parameter int BLOCK_H = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] x_in,
    input  logic [6:0] y_in,
    input  logic [2:0] color_in,
    output logic       busy,
    output logic       done,
    output logic       plot,
    output logic [7:0] x_out,
    output logic [6:0] y_out,
    output logic [2:0] color_out
);

    // Handshake: start is a one-shot request with no backpressure. It is taken only
    // in IDLE; busy covers DRAW and DONE, and any start seen then is dropped, not queued.
    draw_state_t state, next_state;

    logic [7:0] x_base;
    logic [6:0] y_base;
    logic [2:0] color_base;

    logic       accept, advance, last;
    logic [2:0] cx, cy, cx_nxt, cy_nxt;
    logic [7:0] bx, px;
    logic [6:0] by, py;
    logic [2:0] pc;
    logic       pix_vis;

    pixel_scan_counter #(
        .BLOCK_W(BLOCK_W),
        .BLOCK_H(BLOCK_H)
    ) u_scan (
        .clk    (clk),
        .reset  (reset),
        .clear  (accept),
        .advance(advance),
        .cx     (cx),
        .cy     (cy),
        .cx_nxt (cx_nxt),
        .cy_nxt (cy_nxt),
        .last   (last)
    );

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        advance    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    next_state = DRAW;
                end
            end
            DRAW: begin
                if (last) next_state = DONE;
                else      advance    = 1'b1;
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // The pixel for the coming cycle: on accept the base comes straight from the inputs.
    always_comb begin
        bx = accept ? x_in     : x_base;
        by = accept ? y_in     : y_base;
        pc = accept ? color_in : color_base;
        px = bx + {5'd0, cx_nxt};
        py = by + {4'd0, cy_nxt};
`ifdef STRENGTH_DRAW_CLIP_EN
        pix_vis = on_screen({1'b0, bx} + {6'd0, cx_nxt}, {1'b0, by} + {5'd0, cy_nxt});
`else
        pix_vis = 1'b1;
`endif
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            x_base     <= 8'd0;
            y_base     <= 7'd0;
            color_base <= 3'd0;
            plot       <= 1'b0;
            done       <= 1'b0;
            x_out      <= 8'd0;
            y_out      <= 7'd0;
            color_out  <= 3'd0;
        end else begin
            state <= next_state;
            if (accept) begin
                x_base     <= x_in;
                y_base     <= y_in;
                color_base <= color_in;
            end
            plot <= (next_state == DRAW) && pix_vis;
            done <= (state == DRAW) && last;
            // Coordinates hold their last values outside DRAW.
            if (next_state == DRAW) begin
                x_out     <= px;
                y_out     <= py;
                color_out <= pc;
            end
        end
    end

endmodule

// File: tb/tb_strength_bar_drawer.sv
// Scoreboard bench for strength_bar_drawer: expected pixels queued at request time,
// popped as the DUT plots; a second 1x1 instance covers the minimum block size.
module tb_strength_bar_drawer;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] x_in;
    logic [6:0] y_in;
    logic [2:0] color_in;
    logic       busy, done, plot;
    logic [7:0] x_out;
    logic [6:0] y_out;
    logic [2:0] color_out;

    logic       m_start;
    logic       m_busy, m_done, m_plot;
    logic [7:0] m_x_out;
    logic [6:0] m_y_out;
    logic [2:0] m_color_out;

    logic [17:0] exp_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int n_plot  = 0;

    strength_bar_drawer #(.BLOCK_W(7), .BLOCK_H(5)) u_dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .x_in     (x_in),
        .y_in     (y_in),
        .color_in (color_in),
        .busy     (busy),
        .done     (done),
        .plot     (plot),
        .x_out    (x_out),
        .y_out    (y_out),
        .color_out(color_out)
    );

    strength_bar_drawer #(.BLOCK_W(1), .BLOCK_H(1)) u_min (
        .clk      (clk),
        .reset    (reset),
        .start    (m_start),
        .x_in     (8'd0),
        .y_in     (7'd0),
        .color_in (3'b101),
        .busy     (m_busy),
        .done     (m_done),
        .plot     (m_plot),
        .x_out    (m_x_out),
        .y_out    (m_y_out),
        .color_out(m_color_out)
    );

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Reference model: row-major 7x5 scan, optional clipping on unwrapped coordinates.
    task automatic push_block(input int bx, input int by, input logic [2:0] c, output int cnt);
        logic [7:0] wx;
        logic [6:0] wy;
        cnt = 0;
        for (int r = 0; r < 5; r++) begin
            for (int q = 0; q < 7; q++) begin
`ifdef STRENGTH_DRAW_CLIP_EN
                if ((bx + q) >= 160 || (by + r) >= 120) continue;
`endif
                wx = 8'(bx + q);
                wy = 7'(by + r);
                exp_q.push_back({wx, wy, c});
                cnt++;
            end
        end
    endtask

    // Scoreboard pop side
    always @(negedge clk) begin
        if (!reset && plot) begin
            n_plot++;
            if (exp_q.size() == 0) check_eq("unexpected_pixel", {14'd0, x_out, y_out, color_out}, 32'hFFFF_FFFF);
            else                   check_eq("pixel", {14'd0, x_out, y_out, color_out}, {14'd0, exp_q.pop_front()});
        end
    end

    // Driver tasks
    task automatic drive_start(input int bx, input int by, input logic [2:0] c, output int acc);
        @(posedge clk); #1;
        start    = 1'b1;
        x_in     = 8'(bx);
        y_in     = 7'(by);
        color_in = c;
        acc      = cyc;
        @(posedge clk); #1;
        start    = 1'b0;
        x_in     = 8'hAA;
        y_in     = 7'h55;
        color_in = 3'b010;
    endtask

    task automatic wait_done(output int dcyc);
        dcyc = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done) begin
                dcyc = cyc;
                break;
            end
        end
        if (dcyc < 0) check_eq("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int acc, dcyc, cnt;
        reset    = 1'b1;
        start    = 1'b0;
        m_start  = 1'b0;
        x_in     = 8'd0;
        y_in     = 7'd0;
        color_in = 3'd0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_busy", {31'd0, busy}, 32'd0);
        check_eq("reset_done", {31'd0, done}, 32'd0);
        check_eq("reset_plot", {31'd0, plot}, 32'd0);
        check_eq("reset_xyc", {14'd0, x_out, y_out, color_out}, 32'd0);
        reset = 1'b0;

        // Basic draw
        n_plot = 0;
        push_block(45, 73, 3'b110, cnt);
        drive_start(45, 73, 3'b110, acc);
        wait_done(dcyc);
        check_eq("basic_done_cycle", 32'(dcyc - acc), 32'd36);
        check_eq("basic_busy_in_done", {31'd0, busy}, 32'd1);
        check_eq("basic_plot_in_done", {31'd0, plot}, 32'd0);
        @(negedge clk);
        check_eq("basic_busy_after", {31'd0, busy}, 32'd0);
        check_eq("basic_done_pulse", {31'd0, done}, 32'd0);
        check_eq("basic_hold_x", {24'd0, x_out}, 32'd51);
        check_eq("basic_count", 32'(n_plot), 32'd35);
        check_eq("basic_q_empty", 32'(exp_q.size()), 32'd0);

        // Start while busy is dropped
        n_plot = 0;
        push_block(45, 73, 3'b100, cnt);
        drive_start(45, 73, 3'b100, acc);
        repeat (8) @(posedge clk);
        #1;
        start = 1'b1;
        x_in  = 8'd53;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(dcyc);
        check_eq("busy_done_cycle", 32'(dcyc - acc), 32'd36);
        repeat (3) @(negedge clk);
        check_eq("busy_count", 32'(n_plot), 32'd35);
        check_eq("busy_idle", {31'd0, busy}, 32'd0);
        check_eq("busy_q_empty", 32'(exp_q.size()), 32'd0);

        // Reset mid-draw
        push_block(45, 73, 3'b111, cnt);
        drive_start(45, 73, 3'b111, acc);
        repeat (11) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_eq("rst_plot", {31'd0, plot}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_done", {31'd0, done}, 32'd0);
        check_eq("rst_xyc", {14'd0, x_out, y_out, color_out}, 32'd0);
        exp_q.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_stays_idle", {30'd0, busy, plot}, 32'd0);
        n_plot = 0;
        push_block(61, 73, 3'b110, cnt);
        drive_start(61, 73, 3'b110, acc);
        wait_done(dcyc);
        check_eq("rst_redraw_done", 32'(dcyc - acc), 32'd36);
        check_eq("rst_redraw_count", 32'(n_plot), 32'd35);

        // Back-to-back blocks with start held high
        n_plot = 0;
        @(posedge clk); #1;
        start    = 1'b1;
        x_in     = 8'd45;
        y_in     = 7'd73;
        color_in = 3'b101;
        acc      = cyc;
        push_block(45, 73, 3'b101, cnt);
        for (int k = 0; k < 3; k++) begin
            wait_done(dcyc);
            check_eq("b2b_done_cycle", 32'(dcyc - acc), 32'(36 + 37 * k));
            if (k < 2) begin
                x_in = 8'(45 + 8 * (k + 1));
                push_block(45 + 8 * (k + 1), 73, 3'b101, cnt);
            end else begin
                start = 1'b0;
            end
        end
        repeat (3) @(negedge clk);
        check_eq("b2b_count", 32'(n_plot), 32'd105);
        check_eq("b2b_q_empty", 32'(exp_q.size()), 32'd0);

        // Edge block near the bottom-right corner
        n_plot = 0;
        push_block(157, 118, 3'b111, cnt);
        drive_start(157, 118, 3'b111, acc);
        wait_done(dcyc);
        check_eq("edge_done_cycle", 32'(dcyc - acc), 32'd36);
        check_eq("edge_count", 32'(n_plot), 32'(cnt));
        check_eq("edge_q_empty", 32'(exp_q.size()), 32'd0);

        // Minimum 1x1 block on the second instance
        @(posedge clk); #1;
        m_start = 1'b1;
        @(negedge clk);
        check_eq("min_plot_before", {31'd0, m_plot}, 32'd0);
        @(posedge clk); #1;
        m_start = 1'b0;
        @(negedge clk);
        check_eq("min_plot", {31'd0, m_plot}, 32'd1);
        check_eq("min_pixel", {14'd0, m_x_out, m_y_out, m_color_out}, {14'd0, 8'd0, 7'd0, 3'b101});
        check_eq("min_busy", {31'd0, m_busy}, 32'd1);
        @(negedge clk);
        check_eq("min_done", {30'd0, m_done, m_plot}, 32'd2);
        @(negedge clk);
        check_eq("min_idle", {30'd0, m_done, m_busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
